// File: rtl/clock_period_meter_pkg.sv
// Shared types and constants for the clock period meter.
// Optional duty-cycle measurement is enabled with CLOCK_PERIOD_METER_DUTY_EN.
package clock_period_meter_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      TIMEOUT    = 2'd2
   } state_e;

   // Fewest synchroniser flops that still give a metastability guard.
   localparam int unsigned SYNC_MIN  = 2;
   localparam int unsigned DEF_WIDTH = 16;

endpackage

// File: rtl/clock_period_meter_if.sv
// Bundle of the measured-signal inputs and measurement results of the meter.
// highTime only carries data when CLOCK_PERIOD_METER_DUTY_EN is defined.
interface clock_period_meter_if
   import clock_period_meter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             sigIn;
   logic             clear;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] highTime;
   logic             valid;
   logic             locked;
   logic             overflow;

   // Side that drives the signal under test and reads results.
   modport master (
      output sigIn, clear,
      input  period, highTime, valid, locked, overflow
   );

   // The meter itself.
   modport slave (
      input  sigIn, clear,
      output period, highTime, valid, locked, overflow
   );

endinterface

// File: rtl/clock_period_meter_sync.sv
// Synchroniser plus rising-edge detector for an asynchronous level.
// Reusable for button and other slow asynchronous inputs.
module sync_rise_detect
   import clock_period_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   if (SYNC_STAGES < SYNC_MIN) begin : g_bad_depth
      $error("sync_rise_detect: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Shift the async input through the synchroniser and keep one cycle of history.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = level_o & ~hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous signal in system-clock cycles
// and strobes valid for one cycle on each completed measurement.
// Define CLOCK_PERIOD_METER_DUTY_EN to also measure high time per period;
// otherwise highTime is tied to zero and no high-time counter exists.
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sigIn,
   input  logic             clear,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] highTime,
   output logic             valid,
   output logic             locked,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q;
   logic             valid_q, locked_q, overflow_q;
   logic             rise;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
   logic             level;
   logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d, high_time_q;
`else
   logic             level_unused;
`endif

   sync_rise_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (sigIn),
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      .level_o (level),
`else
      .level_o (level_unused),
`endif
      .rise_o  (rise)
   );

   // Next values of the free-running counters (used only below MAX / when high).
   always_comb begin
      cnt_d = cnt_q + ONE;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      hi_cnt_d = hi_cnt_q;
      if (level && (hi_cnt_q != MAX)) hi_cnt_d = hi_cnt_q + ONE;
`endif
   end

   // Measurement FSM; reset beats clear, clear beats a coincident rise.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= WAIT_FIRST;
         cnt_q      <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         overflow_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
         hi_cnt_q    <= '0;
         high_time_q <= '0;
`endif
      end else if (clear) begin
         state_q    <= WAIT_FIRST;
         cnt_q      <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         overflow_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
         hi_cnt_q    <= '0;
         high_time_q <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         // The rise cycle itself is the first cycle (and first high cycle)
         // of the new period, so both counters restart at one.
         unique case (state_q)
            WAIT_FIRST: begin
               cnt_q <= '0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
               hi_cnt_q <= '0;
`endif
               if (rise) begin
                  cnt_q   <= ONE;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                  hi_cnt_q <= ONE;
`endif
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_q <= cnt_q;
                  valid_q  <= 1'b1;
                  locked_q <= 1'b1;
                  cnt_q    <= ONE;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                  high_time_q <= hi_cnt_q;
                  hi_cnt_q    <= ONE;
`endif
               end else if (cnt_q == MAX) begin
                  overflow_q <= 1'b1;
                  locked_q   <= 1'b0;
                  state_q    <= TIMEOUT;
               end else begin
                  cnt_q <= cnt_d;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                  hi_cnt_q <= hi_cnt_d;
`endif
               end
            end
            TIMEOUT: begin
               if (rise) begin
                  cnt_q   <= ONE;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                  hi_cnt_q <= ONE;
`endif
                  state_q <= MEASURE;
               end
            end
            default: state_q <= WAIT_FIRST;
         endcase
      end
   end

   assign period   = period_q;
   assign valid    = valid_q;
   assign locked   = locked_q;
   assign overflow = overflow_q;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
   assign highTime = high_time_q;
`else
   assign highTime = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a 16-bit and a 4-bit instance share
// the stimulus. High-time expectations follow CLOCK_PERIOD_METER_DUTY_EN.
module tb_clock_period_meter;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic sig;
   logic clr;

   always #5 clk = ~clk;

   clock_period_meter_if #(.WIDTH(16)) b16 ();
   clock_period_meter_if #(.WIDTH(4))  b4 ();

   assign b16.sigIn = sig;
   assign b16.clear = clr;
   assign b4.sigIn  = sig;
   assign b4.clear  = clr;

   clock_period_meter #(.WIDTH(16), .SYNC_STAGES(2)) u_dut16 (
      .clock    (clk),
      .reset    (rst),
      .sigIn    (b16.sigIn),
      .clear    (b16.clear),
      .period   (b16.period),
      .highTime (b16.highTime),
      .valid    (b16.valid),
      .locked   (b16.locked),
      .overflow (b16.overflow)
   );

   clock_period_meter #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
      .clock    (clk),
      .reset    (rst),
      .sigIn    (b4.sigIn),
      .clear    (b4.clear),
      .period   (b4.period),
      .highTime (b4.highTime),
      .valid    (b4.valid),
      .locked   (b4.locked),
      .overflow (b4.overflow)
   );

   int checks = 0;
   int errors = 0;
   int vcnt16, vcnt4, lastp16, lasth16, lastp4, bb16, bb4;
   int p16 [16];
   int h16 [16];
   logic prev16, prev4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the edge and log every valid strobe.
   task automatic tick();
      @(posedge clk);
      #1;
      if (b16.valid) begin
         if (prev16) bb16++;
         if (vcnt16 < 16) begin
            p16[vcnt16] = int'(b16.period);
            h16[vcnt16] = int'(b16.highTime);
         end
         vcnt16++;
         lastp16 = int'(b16.period);
         lasth16 = int'(b16.highTime);
      end
      if (b4.valid) begin
         if (prev4) bb4++;
         vcnt4++;
         lastp4 = int'(b4.period);
      end
      prev16 = b16.valid;
      prev4  = b4.valid;
   endtask

   task automatic mark();
      vcnt16 = 0;
      vcnt4  = 0;
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         sig = 1'b1;
         repeat (hi) tick();
         sig = 1'b0;
         repeat (lo) tick();
      end
   endtask

   initial begin
      sig = 1'b0; clr = 1'b0; rst = 1'b0;
      bb16 = 0; bb4 = 0; lastp16 = 0; lasth16 = 0; lastp4 = 0;
      prev16 = 1'b0; prev4 = 1'b0;
      mark();
      repeat (3) tick();
      chk("rst_period",   32'(b16.period),   32'd0);
      chk("rst_high",     32'(b16.highTime), 32'd0);
      chk("rst_valid",    32'(b16.valid),    32'd0);
      chk("rst_locked",   32'(b16.locked),   32'd0);
      chk("rst_overflow", 32'(b16.overflow), 32'd0);
      chk("rst_period4",  32'(b4.period),    32'd0);

      // Period 10, 5 high: first rise discarded, five reports follow.
      rst = 1'b1;
      mark();
      wave(5, 5, 6);
      chk("p10_count",  32'(vcnt16), 32'd5);
      chk("p10_period", 32'(lastp16), 32'd10);
      chk("p10_high",   32'(lasth16), DUTY ? 32'd5 : 32'd0);
      chk("p10_locked", 32'(b16.locked), 32'd1);
      chk("p10_ovf",    32'(b16.overflow), 32'd0);

      // Period 100 (30 high), then a 50-cycle partial period, then period 7.
      wave(30, 70, 4);
      chk("p100_period", 32'(lastp16), 32'd100);
      chk("p100_high",   32'(lasth16), DUTY ? 32'd30 : 32'd0);
      mark();
      sig = 1'b1; repeat (30) tick();
      sig = 1'b0; repeat (20) tick();
      wave(3, 4, 10);
      chk("sw_count",  32'(vcnt16), 32'd11);
      chk("sw_p0",     32'(p16[0]), 32'd100);
      chk("sw_p1",     32'(p16[1]), 32'd50);
      chk("sw_h1",     32'(h16[1]), DUTY ? 32'd30 : 32'd0);
      chk("sw_p2",     32'(p16[2]), 32'd7);
      chk("sw_last",   32'(lastp16), 32'd7);
      chk("sw_lasth",  32'(lasth16), DUTY ? 32'd3 : 32'd0);

      // WIDTH=4 overflow: lock at period 6, then hold low until timeout.
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_period4", 32'(b4.period), 32'd0);
      wave(3, 3, 3);
      repeat (11) tick();
      chk("ovf_pre",    32'(b4.overflow), 32'd0);
      chk("ovf_prelck", 32'(b4.locked),   32'd1);
      tick();
      chk("ovf_set",    32'(b4.overflow), 32'd1);
      chk("ovf_unlock", 32'(b4.locked),   32'd0);
      chk("ovf_hold",   32'(b4.period),   32'd6);
      mark();
      wave(3, 3, 2);
      chk("relock_count",  32'(vcnt4),     32'd1);
      chk("relock_period", 32'(lastp4),    32'd6);
      chk("relock_locked", 32'(b4.locked), 32'd1);
      chk("relock_sticky", 32'(b4.overflow), 32'd1);

      // clear on the same cycle the rise reaches the FSM.
      sig = 1'b1; tick(); tick();
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clrrise_valid",  32'(b16.valid),   32'd0);
      chk("clrrise_period", 32'(b16.period),  32'd0);
      chk("clrrise_locked", 32'(b16.locked),  32'd0);
      chk("clrrise_ovf4",   32'(b4.overflow), 32'd0);
      chk("clrrise_lock4",  32'(b4.locked),   32'd0);
      mark();
      sig = 1'b0; repeat (3) tick();
      wave(3, 3, 2);
      chk("clrrise_count",  32'(vcnt16),  32'd1);
      chk("clrrise_after",  32'(lastp16), 32'd6);
      chk("clrrise_count4", 32'(vcnt4),   32'd1);

      // WIDTH=4: period of exactly MAX reports without overflow.
      clr = 1'b1; tick(); clr = 1'b0;
      mark();
      wave(7, 8, 3);
      chk("max_count",  32'(vcnt4),       32'd2);
      chk("max_period", 32'(lastp4),      32'd15);
      chk("max_ovf",    32'(b4.overflow), 32'd0);
      chk("max_locked", 32'(b4.locked),   32'd1);

      // Reset pulsed while sigIn is high, released after it falls.
      sig = 1'b1; tick(); tick();
      rst = 1'b0; tick();
      chk("mrst_period", 32'(b16.period),   32'd0);
      chk("mrst_high",   32'(b16.highTime), 32'd0);
      chk("mrst_valid",  32'(b16.valid),    32'd0);
      chk("mrst_locked", 32'(b16.locked),   32'd0);
      chk("mrst_ovf4",   32'(b4.overflow),  32'd0);
      tick();
      sig = 1'b0; tick(); tick();
      rst = 1'b1;
      mark();
      tick(); tick();
      wave(4, 4, 2);
      chk("mrst_count",  32'(vcnt16),  32'd1);
      chk("mrst_after",  32'(lastp16), 32'd8);
      chk("mrst_afterh", 32'(lasth16), DUTY ? 32'd4 : 32'd0);
      chk("mrst_count4", 32'(vcnt4),   32'd1);

      // Minimum period: sigIn toggles every cycle.
      clr = 1'b1; tick(); clr = 1'b0;
      mark();
      wave(1, 1, 10);
      repeat (4) tick();
      chk("min_count",  32'(vcnt16),  32'd9);
      chk("min_first",  32'(p16[0]),  32'd2);
      chk("min_period", 32'(lastp16), 32'd2);
      chk("min_high",   32'(lasth16), DUTY ? 32'd1 : 32'd0);
      chk("min_count4", 32'(vcnt4),   32'd9);
      chk("b2b_16",     32'(bb16),    32'd0);
      chk("b2b_4",      32'(bb4),     32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
